// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcodes, R-type function codes and the mul/div sequencer states.
package mips_pkg;

   localparam logic [5:0] OPCODE_RTYPE = 6'h00;
   localparam logic [5:0] OPCODE_ADDIU = 6'h09;
   localparam logic [5:0] OPCODE_LW    = 6'h23;
   localparam logic [5:0] OPCODE_SW    = 6'h2b;

   localparam logic [5:0] FUNCT_SLL   = 6'h00;
   localparam logic [5:0] FUNCT_SRL   = 6'h02;
   localparam logic [5:0] FUNCT_SRA   = 6'h03;
   localparam logic [5:0] FUNCT_SLLV  = 6'h04;
   localparam logic [5:0] FUNCT_SRLV  = 6'h06;
   localparam logic [5:0] FUNCT_SRAV  = 6'h07;
   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1a;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
   localparam logic [5:0] FUNCT_ADDU  = 6'h21;
   localparam logic [5:0] FUNCT_SUBU  = 6'h23;
   localparam logic [5:0] FUNCT_AND   = 6'h24;
   localparam logic [5:0] FUNCT_OR    = 6'h25;
   localparam logic [5:0] FUNCT_XOR   = 6'h26;
   localparam logic [5:0] FUNCT_NOR   = 6'h27;
   localparam logic [5:0] FUNCT_SLT   = 6'h2a;
   localparam logic [5:0] FUNCT_SLTU  = 6'h2b;

   typedef enum logic [1:0] {StIdle, StIter, StFix} md_state_e;

   // MULT, MULTU, DIV, DIVU occupy 0x18..0x1b
   function automatic logic is_muldiv(logic [5:0] f);
      return f[5:2] == 4'b0110;
   endfunction

endpackage

// File: rtl/mips_muldiv.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, 32 steps plus a sign
// fix-up cycle. hi/lo outputs are valid while done is high.
module mips_muldiv
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        is_div,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e   state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] dvs_q, a_q;
   logic        div_q, neg_q, neg_rem_q, div0_q;
   logic [31:0] a_abs, b_abs;
   logic [32:0] sum;
   logic [32:0] shifted;
   logic [33:0] diff;
   logic [63:0] prod;

   assign a_abs = (is_signed && a[31]) ? (~a + 32'd1) : a;
   assign b_abs = (is_signed && b[31]) ? (~b + 32'd1) : b;
   assign busy  = (state_q != StIdle);
   assign done  = (state_q == StFix);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sum     = {1'b0, acc_q[63:32]} + {1'b0, dvs_q};
      shifted = {acc_q[63:32], acc_q[31]};
      diff    = {1'b0, shifted} - {2'b00, dvs_q};
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StIter;
               cnt_d   = 5'd31;
               acc_d   = {32'd0, a_abs};
            end
         end
         StIter: begin
            // acc holds {partial hi, remaining multiplier} or {remainder, dividend/quotient}
            if (div_q) begin
               acc_d = diff[33] ? {shifted[31:0], acc_q[30:0], 1'b0}
                                : {diff[31:0], acc_q[30:0], 1'b1};
            end else begin
               acc_d = acc_q[0] ? {sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
            end
            if (cnt_q == 5'd0) state_d = StFix;
            else               cnt_d   = cnt_q - 5'd1;
         end
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         cnt_q     <= 5'd0;
         acc_q     <= 64'd0;
         dvs_q     <= 32'd0;
         a_q       <= 32'd0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         if (state_q == StIdle && start) begin
            dvs_q     <= b_abs;
            a_q       <= a;
            div_q     <= is_div;
            neg_q     <= is_signed & (a[31] ^ b[31]);
            neg_rem_q <= is_signed & a[31];
            div0_q    <= (b == 32'd0);
         end
      end
   end

   always_comb begin
      prod = neg_q ? (~acc_q + 64'd1) : acc_q;
      hi   = prod[63:32];
      lo   = prod[31:0];
      if (div_q) begin
         if (div0_q) begin
            hi = a_q;
            lo = 32'hFFFF_FFFF;
         end else begin
            lo = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
            hi = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
         end
      end
   end

endmodule

// File: rtl/alu_exec.sv
// MIPS execute-stage ALU: single-cycle logic/arith/shift/HI-LO moves, with iterative
// multiply/divide delegated to mips_muldiv.
module alu_exec
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [5:0]  fncode,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   output logic        ready,
   output logic        done,
   output logic [31:0] result,
   output logic        zero,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        illegal
);

   logic        accept, is_md;
   logic        md_busy, md_done;
   logic [31:0] md_hi, md_lo;
   logic [31:0] alu_res;
   logic        alu_ill, hi_wr, lo_wr;
   logic        done_q, ill_q;
   logic [31:0] result_q, hi_q, lo_q;

   assign is_md  = is_muldiv(fncode);
   assign ready  = ~md_busy;
   assign accept = start & ready;

   mips_muldiv u_muldiv (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (accept & is_md),
      .is_div    (fncode[1]),
      .is_signed (~fncode[0]),
      .a         (a),
      .b         (b),
      .busy      (md_busy),
      .done      (md_done),
      .hi        (md_hi),
      .lo        (md_lo)
   );

   always_comb begin
      alu_res = 32'd0;
      alu_ill = 1'b0;
      hi_wr   = 1'b0;
      lo_wr   = 1'b0;
      case (fncode)
         FUNCT_ADDU: alu_res = a + b;
         FUNCT_SUBU: alu_res = a - b;
         FUNCT_AND:  alu_res = a & b;
         FUNCT_OR:   alu_res = a | b;
         FUNCT_XOR:  alu_res = a ^ b;
         FUNCT_NOR:  alu_res = ~(a | b);
         FUNCT_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
         FUNCT_SLTU: alu_res = {31'd0, a < b};
         FUNCT_SLL:  alu_res = b << shamt;
         FUNCT_SRL:  alu_res = b >> shamt;
         FUNCT_SRA:  alu_res = $signed(b) >>> shamt;
         FUNCT_SLLV: alu_res = b << a[4:0];
         FUNCT_SRLV: alu_res = b >> a[4:0];
         FUNCT_SRAV: alu_res = $signed(b) >>> a[4:0];
         FUNCT_MFHI: alu_res = hi_q;
         FUNCT_MFLO: alu_res = lo_q;
         FUNCT_MTHI: hi_wr   = 1'b1;
         FUNCT_MTLO: lo_wr   = 1'b1;
         default:    alu_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done_q   <= 1'b0;
         ill_q    <= 1'b0;
         result_q <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         done_q <= 1'b0;
         ill_q  <= 1'b0;
         if (accept && !is_md) begin
            done_q   <= 1'b1;
            ill_q    <= alu_ill;
            result_q <= alu_res;
            if (hi_wr) hi_q <= a;
            if (lo_wr) lo_q <= a;
         end else if (md_done) begin
            done_q   <= 1'b1;
            result_q <= md_lo;
            hi_q     <= md_hi;
            lo_q     <= md_lo;
         end
      end
   end

   assign done    = done_q;
   assign illegal = ill_q;
   assign result  = result_q;
   assign zero    = (result_q == 32'd0);
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed and randomized checks of alu_exec against a plain-arithmetic reference model.
module tb_alu_exec;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [5:0]  fncode;
   logic [31:0] a, b;
   logic [4:0]  shamt;
   logic        ready, done, zero, illegal;
   logic [31:0] result, hi, lo;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi, m_lo, m_res;

   localparam int NLEGAL = 22;
   logic [5:0] legal_fn [NLEGAL] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11,
                                     6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h21, 6'h23,
                                     6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

   always #5 clk = ~clk;

   alu_exec dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .fncode  (fncode),
      .a       (a),
      .b       (b),
      .shamt   (shamt),
      .ready   (ready),
      .done    (done),
      .result  (result),
      .zero    (zero),
      .hi      (hi),
      .lo      (lo),
      .illegal (illegal)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Architectural effect of one operation, from plain integer arithmetic.
   task automatic model(input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] sh, output logic [31:0] res, output logic ill,
                        output int lat);
      int          sx, sy;
      longint      sp, sq, sr;
      logic [63:0] up;
      sx  = x;
      sy  = y;
      res = 32'd0;
      ill = 1'b0;
      lat = 1;
      case (fn)
         6'h21: res = x + y;
         6'h23: res = x - y;
         6'h24: res = x & y;
         6'h25: res = x | y;
         6'h26: res = x ^ y;
         6'h27: res = ~(x | y);
         6'h2a: res = (sx < sy) ? 32'd1 : 32'd0;
         6'h2b: res = (x < y) ? 32'd1 : 32'd0;
         6'h00: res = y << sh;
         6'h02: res = y >> sh;
         6'h03: res = sy >>> sh;
         6'h04: res = y << x[4:0];
         6'h06: res = y >> x[4:0];
         6'h07: res = sy >>> x[4:0];
         6'h10: res = m_hi;
         6'h12: res = m_lo;
         6'h11: m_hi = x;
         6'h13: m_lo = x;
         6'h18: begin
            sp = longint'(sx) * longint'(sy);
            up = sp;
            {m_hi, m_lo} = up;
         end
         6'h19: begin
            up = {32'd0, x} * {32'd0, y};
            {m_hi, m_lo} = up;
         end
         6'h1a: begin
            if (y == 32'd0) begin
               m_lo = 32'hFFFF_FFFF;
               m_hi = x;
            end else begin
               sq = longint'(sx) / longint'(sy);
               sr = longint'(sx) % longint'(sy);
               m_lo = sq[31:0];
               m_hi = sr[31:0];
            end
         end
         6'h1b: begin
            if (y == 32'd0) begin
               m_lo = 32'hFFFF_FFFF;
               m_hi = x;
            end else begin
               m_lo = x / y;
               m_hi = x % y;
            end
         end
         default: ill = 1'b1;
      endcase
      if (fn >= 6'h18 && fn <= 6'h1b) begin
         lat = 34;
         res = m_lo;
      end
   endtask

   task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] sh);
      logic [31:0] e_res;
      logic        e_ill;
      int          lat, cyc;
      logic        rdy_ok;
      model(fn, x, y, sh, e_res, e_ill, lat);
      @(negedge clk);
      chk({tag, ":ready_before"}, ready, 1'b1);
      start = 1'b1; fncode = fn; a = x; b = y; shamt = sh;
      @(posedge clk); #1;
      start = 1'b0; fncode = 6'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
      cyc    = 1;
      rdy_ok = 1'b1;
      while (done !== 1'b1 && cyc < 40) begin
         if (ready !== (lat == 1)) rdy_ok = 1'b0;
         // stray requests while busy must be dropped
         if (lat != 1) start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      chk({tag, ":latency"}, cyc, lat);
      chk({tag, ":ready_busy"}, rdy_ok, 1'b1);
      chk({tag, ":result"}, result, e_res);
      chk({tag, ":zero"}, zero, e_res == 32'd0);
      chk({tag, ":illegal"}, illegal, e_ill);
      chk({tag, ":hi"}, hi, m_hi);
      chk({tag, ":lo"}, lo, m_lo);
      chk({tag, ":ready_done"}, ready, 1'b1);
      @(posedge clk); #1;
      chk({tag, ":done_pulse"}, done, 1'b0);
      chk({tag, ":illegal_clr"}, illegal, 1'b0);
      chk({tag, ":result_hold"}, result, e_res);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic       saw_done;
      logic [5:0] fn;
      reset_n = 1'b0; start = 1'b0; fncode = 6'd0; a = 32'd0; b = 32'd0; shamt = 5'd0;
      m_hi = 32'd0; m_lo = 32'd0;
      #12;
      chk("rst:ready", ready, 1'b1);
      chk("rst:done", done, 1'b0);
      chk("rst:illegal", illegal, 1'b0);
      chk("rst:result", result, 32'd0);
      chk("rst:zero", zero, 1'b1);
      chk("rst:hi", hi, 32'd0);
      chk("rst:lo", lo, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      run_op("addu_wrap", 6'h21, 32'hFFFF_FFFF, 32'd1, 5'd0);
      run_op("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'd7, 5'd0);
      chk("mult_neg:hi_const", hi, 32'hFFFF_FFFF);
      chk("mult_neg:lo_const", lo, 32'hFFFF_FFEB);
      run_op("div_neg", 6'h1a, 32'hFFFF_FFF9, 32'd2, 5'd0);
      chk("div_neg:lo_const", lo, 32'hFFFF_FFFD);
      chk("div_neg:hi_const", hi, 32'hFFFF_FFFF);
      run_op("divu_zero", 6'h1b, 32'd7, 32'd0, 5'd0);
      run_op("div_zero_neg", 6'h1a, 32'hFFFF_FFF0, 32'd0, 5'd0);
      run_op("div_ovf", 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
      chk("div_ovf:lo_const", lo, 32'h8000_0000);
      chk("div_ovf:hi_const", hi, 32'd0);
      run_op("mthi", 6'h11, 32'h1234_5678, 32'd0, 5'd0);
      run_op("mfhi", 6'h10, 32'd0, 32'd0, 5'd0);
      chk("mfhi:result_const", result, 32'h1234_5678);
      run_op("illegal_3f", 6'h3f, 32'h55, 32'h66, 5'd0);
      run_op("sra", 6'h03, 32'd0, 32'h8000_00F0, 5'd4);

      // abort a MULTU partway through the iteration phase
      @(negedge clk);
      start = 1'b1; fncode = 6'h19; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort:ready", ready, 1'b1);
      chk("abort:done", done, 1'b0);
      chk("abort:hi", hi, 32'd0);
      chk("abort:lo", lo, 32'd0);
      chk("abort:zero", zero, 1'b1);
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      reset_n = 1'b1;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      chk("abort:no_done", saw_done, 1'b0);
      chk("abort:hi_after", hi, 32'd0);
      run_op("addu_after_abort", 6'h21, 32'd40, 32'd2, 5'd0);

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
         else fn = legal_fn[$urandom_range(0, NLEGAL - 1)];
         run_op($sformatf("rand%0d_fn%0h", i, fn), fn, pick_operand(), pick_operand(),
                5'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request to execute one operation; sampled only while ready=1.
REQ-004 SHALL have port fncode, input, 6, ALU function code as produced by the ALU control stage (rtype funct, or FUNCT_ADDU for ADDIU/LW/SW, or 6'b111111).
REQ-005 SHALL have ports a, b, input, 32 each, operands (a=rs, b=rt or extended immediate).
REQ-006 SHALL have port shamt, input, 5, shift amount for SLL/SRL/SRA.
REQ-007 SHALL have port ready, output, 1, high when idle and able to accept start.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking result/hi/lo valid for the completed operation.
REQ-009 SHALL have ports result, output, 32, registered result; zero, output, 1, result==0.
REQ-010 SHALL have ports hi, lo, output, 32 each, architectural HI/LO registers.
REQ-011 SHALL have port illegal, output, 1, registered flag set with done when fncode is unsupported.

Function
REQ-012 SHALL accept an operation on a rising edge where start=1 and ready=1; start with ready=0 is ignored, no queuing.
REQ-013 SHALL latch fncode, a, b, shamt at acceptance; later input changes have no effect on that operation.
REQ-014 Single-cycle ops: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, MFHI, MFLO, MTHI, MTLO; done=1 in the cycle immediately after the accept edge; ready stays 1.
REQ-015 Arithmetic SHALL wrap modulo 2^32, no overflow detection; SLT signed, SLTU unsigned, result 32'd1/32'd0; variable shifts use b-shift amount a[4:0] (rs), b shifted.
REQ-016 MTHI/MTLO SHALL write a to hi/lo on the completing edge; result=0.
REQ-017 Iterative ops MULT, MULTU, DIV, DIVU SHALL use states IDLE -> ITER (exactly 32 cycles, 5-bit counter 31..0) -> FIX (1 cycle) -> IDLE; ready=0 from accept edge until return to IDLE.
REQ-018 Iterative ops SHALL assert done exactly 34 cycles after the accept cycle; hi/lo updated on the same edge done rises; result=lo.
REQ-019 MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product.
REQ-020 DIV/DIVU: lo=quotient, hi=remainder; signed: quotient truncates toward zero, remainder takes dividend sign; sign fix-up performed in FIX.
REQ-021 Divide by zero SHALL complete with normal latency: lo=32'hFFFF_FFFF, hi=a, no sign fix-up.
REQ-022 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL give lo=32'h8000_0000, hi=0.
REQ-023 Unsupported fncode (including 6'b111111): single-cycle, done=1, illegal=1, result=0, hi/lo unchanged.
REQ-024 hi/lo SHALL change only on completion of MULT*/DIV*/MTHI/MTLO.
REQ-025 done and illegal SHALL be 0 in every cycle except the completion cycle; result holds its value until the next completion.

Reset
REQ-026 reset_n=0 SHALL immediately force: state IDLE, ready=1, done=0, illegal=0, result=0, zero=1, hi=0, lo=0, counter=0.
REQ-027 Reset mid-ITER/FIX SHALL abort the operation with no done pulse and no hi/lo write.
REQ-028 First accept SHALL be possible on the first rising edge with reset_n=1.

Structure
REQ-029 FUNCT_* and OPCODE_* constants and the IDLE/ITER/FIX state enum SHALL live in the shared mips package; no local redefinition.
REQ-030 The shift-add multiplier / restoring divider datapath SHALL be one sub-module, mips_muldiv, with start/busy/done handshake; single-cycle ops stay in alu_exec.

Verification
REQ-031 ADDU a=32'hFFFF_FFFF b=1, start -> next cycle done=1, result=0, zero=1, ready never drops.
REQ-032 MULT a=-3 b=7 -> done 34 cycles later, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB; start pulses during busy ignored.
REQ-033 DIV a=-7 b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIVU a=7 b=0 -> lo=32'hFFFF_FFFF, hi=7.
REQ-034 MTHI a=32'h1234_5678 then MFHI -> result=32'h1234_5678; fncode 6'b111111 -> illegal=1, hi/lo unchanged.
REQ-035 MULTU started, reset_n pulsed low at ITER cycle 10 -> no done, hi=lo=0, ready=1; next ADDU completes normally.
